// File: rtl/lcd_msg_pkg.sv
// Shared constants, state encoding and the character template for the LCD message scheduler.
package lcd_msg_pkg;

    localparam int unsigned COLS      = 16;
    localparam int unsigned COL_W     = $clog2(COLS);
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned DIGIT_COL = 6;
    localparam int unsigned VAL_W     = 10;
    localparam int unsigned BCD_W     = 4 * DIGITS;
    localparam int unsigned MSG_W     = 3;

    localparam logic [MSG_W-1:0] MSG_BLANK = 3'd0;
    localparam logic [MSG_W-1:0] MSG_WAIT  = 3'd1;
    localparam logic [MSG_W-1:0] MSG_CHEAT = 3'd2;
    localparam logic [MSG_W-1:0] MSG_SLOW  = 3'd3;
    localparam logic [MSG_W-1:0] MSG_TIME  = 3'd4;
    localparam logic [MSG_W-1:0] MSG_BEST  = 3'd5;

    typedef enum logic [1:0] {
        S_Idle    = 2'd0,
        S_Convert = 2'd1,
        S_Send    = 2'd2,
        S_Ack     = 2'd3
    } state_t;

    function automatic logic is_numeric(input logic [MSG_W-1:0] msg);
        return (msg == MSG_TIME) || (msg == MSG_BEST);
    endfunction

    // ASCII for one column; digit field blanks leading zeros but always shows units
    function automatic logic [7:0] template_char(input logic [MSG_W-1:0] msg,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [BCD_W-1:0] bcd);
        logic [8*COLS-1:0] txt;
        logic [1:0]        pos;
        logic [BCD_W-1:0]  sh;
        logic [BCD_W-1:0]  upper;
        logic [7:0]        ch;
        logic              in_digits;
        case (msg)
            MSG_WAIT:  txt = "WAIT...         ";
            MSG_CHEAT: txt = "CHEAT!          ";
            MSG_SLOW:  txt = "TOO SLOW        ";
            MSG_TIME:  txt = "TIME:      ms   ";
            MSG_BEST:  txt = "BEST:      ms   ";
            default:   txt = {COLS{8'h20}};
        endcase
        txt       = txt << {col, 3'b000};
        ch        = txt[8*COLS-1 -: 8];
        in_digits = is_numeric(msg) && (col >= COL_W'(DIGIT_COL))
                    && (col < COL_W'(DIGIT_COL + DIGITS));
        pos       = 2'(col - COL_W'(DIGIT_COL));
        sh        = bcd << {pos, 2'b00};
        upper     = bcd >> {2'(2'd3 - pos), 2'b00};
        if (in_digits) begin
            ch = ((pos == 2'd3) || (upper != '0)) ? (8'h30 + {4'h0, sh[BCD_W-1 -: 4]}) : 8'h20;
        end
        return ch;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: first shift happens on the start edge, done pulses after the tenth.
module bin2bcd_seq
    import lcd_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        adj    = dabble_adj(start ? '0 : bcd_q);
        if (start) begin
            bcd_d = {adj[BCD_W-2:0], value[VAL_W-1]};
            bin_d = value << 1;
            cnt_d = CNT_W'(VAL_W - 1);
        end else if (cnt_q != '0) begin
            bcd_d  = {adj[BCD_W-2:0], bin_q[VAL_W-1]};
            bin_d  = bin_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Arbitrates two LCD line owners and streams one 16-character line per granted request.
module lcd_msg_scheduler
    import lcd_msg_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqA,
    input  logic [MSG_W-1:0] MsgA,
    input  logic [VAL_W-1:0] ValueA,
    output logic             AckA,
    input  logic             ReqB,
    input  logic [MSG_W-1:0] MsgB,
    input  logic [VAL_W-1:0] ValueB,
    output logic             AckB,
    output logic [7:0]       CharData,
    output logic [COL_W:0]   CharAddr,
    output logic             CharValid,
    input  logic             CharReady,
    output logic             Busy
);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d, col_nxt;
    logic [MSG_W-1:0]   msg_q, msg_d, msg_sel;
    logic [VAL_W-1:0]   value_sel;
    logic               line_q, line_d;
    logic               last_b_q, last_b_d;
    logic               hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic               valid_q, valid_d, busy_q, busy_d;
    logic [7:0]         data_q, data_d;
    logic [COL_W:0]     addr_q, addr_d;
    logic               elig_a, elig_b, pick_b, grant;
    logic               start_c, bcd_done;
    logic [BCD_W-1:0]   bcd;

    bin2bcd_seq u_bcd (
        .clk   (Clk),
        .rst   (Rst),
        .start (start_c),
        .value (value_sel),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    // Holdoff masks a requester that drops Req one cycle after its Ack
    assign elig_a    = ReqA && !hold_a_q;
    assign elig_b    = ReqB && !hold_b_q;
    assign pick_b    = elig_b && (!elig_a || !last_b_q);
    assign grant     = elig_a || elig_b;
    assign msg_sel   = pick_b ? MsgB : MsgA;
    assign value_sel = pick_b ? ValueB : ValueA;
    assign col_nxt   = col_q + COL_W'(1);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        msg_d    = msg_q;
        line_d   = line_q;
        last_b_d = last_b_q;
        hold_a_d = 1'b0;
        hold_b_d = 1'b0;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        valid_d  = valid_q;
        data_d   = data_q;
        addr_d   = addr_q;
        start_c  = 1'b0;
        case (state_q)
            S_Idle: begin
                if (grant) begin
                    msg_d    = msg_sel;
                    line_d   = pick_b;
                    last_b_d = pick_b;
                    col_d    = '0;
                    if (is_numeric(msg_sel)) begin
                        start_c = 1'b1;
                        state_d = S_Convert;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = template_char(msg_sel, '0, bcd);
                        addr_d  = {pick_b, {COL_W{1'b0}}};
                        state_d = S_Send;
                    end
                end
            end
            S_Convert: begin
                if (bcd_done) begin
                    valid_d = 1'b1;
                    data_d  = template_char(msg_q, '0, bcd);
                    addr_d  = {line_q, {COL_W{1'b0}}};
                    state_d = S_Send;
                end
            end
            S_Send: begin
                if (CharReady) begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        valid_d = 1'b0;
                        ack_a_d = !line_q;
                        ack_b_d = line_q;
                        state_d = S_Ack;
                    end else begin
                        col_d  = col_nxt;
                        data_d = template_char(msg_q, col_nxt, bcd);
                        addr_d = {line_q, col_nxt};
                    end
                end
            end
            S_Ack: begin
                hold_a_d = !line_q;
                hold_b_d = line_q;
                state_d  = S_Idle;
            end
            default: state_d = S_Idle;
        endcase
        busy_d = (state_d != S_Idle);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_Idle;
            col_q    <= '0;
            msg_q    <= '0;
            line_q   <= 1'b0;
            last_b_q <= 1'b1;
            hold_a_q <= 1'b0;
            hold_b_q <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            msg_q    <= msg_d;
            line_q   <= line_d;
            last_b_q <= last_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
        end
    end

    assign AckA      = ack_a_q;
    assign AckB      = ack_b_q;
    assign CharValid = valid_q;
    assign CharData  = data_q;
    assign CharAddr  = addr_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler: rendered lines, latency, arbitration, stalls and reset.
module tb_lcd_msg_scheduler;

    logic       Clk, Rst;
    logic       ReqA, ReqB, AckA, AckB;
    logic [2:0] MsgA, MsgB;
    logic [9:0] ValueA, ValueB;
    logic [7:0] CharData;
    logic [4:0] CharAddr;
    logic       CharValid, CharReady, Busy;

    int errs   = 0;
    int checks = 0;

    localparam logic [127:0] S_WAIT  = "WAIT...         ";
    localparam logic [127:0] S_CHEAT = "CHEAT!          ";
    localparam logic [127:0] S_SLOW  = "TOO SLOW        ";
    localparam logic [127:0] S_BLANK = "                ";
    localparam logic [127:0] S_T347  = "TIME:  347 ms   ";
    localparam logic [127:0] S_T0    = "TIME:    0 ms   ";
    localparam logic [127:0] S_T1023 = "TIME: 1023 ms   ";
    localparam logic [127:0] S_B250  = "BEST:  250 ms   ";

    lcd_msg_scheduler dut (
        .Clk(Clk), .Rst(Rst),
        .ReqA(ReqA), .MsgA(MsgA), .ValueA(ValueA), .AckA(AckA),
        .ReqB(ReqB), .MsgB(MsgB), .ValueB(ValueB), .AckB(AckB),
        .CharData(CharData), .CharAddr(CharAddr), .CharValid(CharValid),
        .CharReady(CharReady), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Collects one transfer; cycle n=1 is the cycle after the one in which Req was set
    task automatic capture(input int stall_col, input logic [127:0] exp,
                           output logic [127:0] got, output int first_n, output int first_col,
                           output int ack_n, output logic ack_b, output logic line);
        int   nchar  = 0;
        int   stalls = 0;
        logic order_ok = 1'b1;
        got = {16{8'h3F}};
        first_n = -1; first_col = -1; ack_n = -1; ack_b = 1'b0; line = 1'b0;
        for (int n = 1; n <= 80 && ack_n < 0; n++) begin
            @(negedge Clk);
            if (CharValid && stall_col >= 0 && int'(CharAddr[3:0]) == stall_col && stalls < 5) begin
                check("stall_data", 128'(CharData), 128'(exp[8*(15-stall_col) +: 8]));
                check("stall_addr", 128'(CharAddr[3:0]), 128'(stall_col));
                CharReady = 1'b0;
                stalls++;
            end else begin
                CharReady = 1'b1;
            end
            if (CharValid && CharReady) begin
                if (first_n < 0) begin
                    first_n = n; first_col = int'(CharAddr[3:0]); line = CharAddr[4];
                end
                if (int'(CharAddr[3:0]) != nchar || CharAddr[4] != line) order_ok = 1'b0;
                got[8*(15-int'(CharAddr[3:0])) +: 8] = CharData;
                nchar++;
            end
            if (AckA || AckB) begin
                ack_n = n; ack_b = AckB;
                if (AckA && AckB) order_ok = 1'b0;
            end
        end
        CharReady = 1'b1;
        check("char_count", 128'(nchar), 128'(16));
        check("col_order", 128'(order_ok), 128'(1));
    endtask

    logic [127:0] got;
    int           fn, fc, an;
    logic         ab, ln;
    logic         seen;
    logic [9:0]   vals [3]  = '{10'd347, 10'd0, 10'd1023};
    logic [127:0] vexp [3]  = '{S_T347, S_T0, S_T1023};
    logic [127:0] rrexp [4] = '{S_CHEAT, S_SLOW, S_BLANK, S_SLOW};

    initial begin
        Rst = 1'b1; ReqA = 1'b0; ReqB = 1'b0; MsgA = '0; MsgB = '0;
        ValueA = '0; ValueB = '0; CharReady = 1'b1;
        #2;
        check("rst_valid", 128'(CharValid), 128'(0));
        check("rst_acks", 128'({AckA, AckB}), 128'(0));
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_data", 128'({CharData, CharAddr}), 128'(0));
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Plain text on line 0, then Req held one cycle past the Ack
        ReqA = 1'b1; MsgA = 3'd1;
        capture(-1, S_WAIT, got, fn, fc, an, ab, ln);
        check("wait_text", got, S_WAIT);
        check("wait_first", 128'(fn), 128'(1));
        check("wait_line", 128'(ln), 128'(0));
        check("wait_ack_cyc", 128'(an), 128'(17));
        check("wait_ack_port", 128'(ab), 128'(0));
        @(negedge Clk);
        check("ack_single", 128'({AckA, AckB}), 128'(0));
        check("busy_after_ack", 128'(Busy), 128'(0));
        @(negedge Clk);
        ReqA = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (CharValid || Busy || AckA || AckB) seen = 1'b1;
        end
        check("holdoff_no_retx", 128'(seen), 128'(0));

        // Numeric rendering with leading-zero blanking
        for (int i = 0; i < 3; i++) begin
            ReqA = 1'b1; MsgA = 3'd4; ValueA = vals[i];
            capture(-1, vexp[i], got, fn, fc, an, ab, ln);
            ReqA = 1'b0;
            check("time_text", got, vexp[i]);
            check("time_first", 128'(fn), 128'(11));
            check("time_ack_cyc", 128'(an), 128'(27));
            repeat (2) @(negedge Clk);
        end

        // Both requesting from reset: A, B, A, B
        Rst = 1'b1; ReqA = 1'b1; ReqB = 1'b1; MsgA = 3'd2; MsgB = 3'd3;
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            capture(-1, rrexp[i], got, fn, fc, an, ab, ln);
            if (i == 0) MsgA = 3'd7;
            check("rr_text", got, rrexp[i]);
            check("rr_port", 128'(ab), 128'(i % 2));
            check("rr_line", 128'(ln), 128'(i % 2));
            check("rr_ack_cyc", 128'(an), 128'(i == 0 ? 17 : 18));
        end
        ReqA = 1'b0; ReqB = 1'b0;
        @(negedge Clk);
        check("rr_ack_single", 128'({AckA, AckB}), 128'(0));
        check("rr_idle", 128'(Busy), 128'(0));
        repeat (2) @(negedge Clk);

        // Back-pressure on column 3
        ReqA = 1'b1; MsgA = 3'd1;
        capture(3, S_WAIT, got, fn, fc, an, ab, ln);
        ReqA = 1'b0;
        check("stall_text", got, S_WAIT);
        check("stall_ack_cyc", 128'(an), 128'(22));
        repeat (2) @(negedge Clk);

        // Reset mid-transfer at column 7
        ReqA = 1'b1; MsgA = 3'd1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge Clk);
            if (CharValid && CharAddr == 5'h07) seen = 1'b1;
        end
        check("col7_reached", 128'(seen), 128'(1));
        Rst = 1'b1;
        #1;
        check("rst_mid_valid", 128'(CharValid), 128'(0));
        check("rst_mid_busy", 128'(Busy), 128'(0));
        ReqA = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (AckA || AckB || CharValid) seen = 1'b1;
        end
        Rst = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (AckA || AckB || CharValid) seen = 1'b1;
        end
        check("rst_mid_no_ack", 128'(seen), 128'(0));
        ReqB = 1'b1; MsgB = 3'd5; ValueB = 10'd250;
        capture(-1, S_B250, got, fn, fc, an, ab, ln);
        ReqB = 1'b0;
        check("best_text", got, S_B250);
        check("best_first_col", 128'(fc), 128'(0));
        check("best_line", 128'(ln), 128'(1));
        check("best_ack_port", 128'(ab), 128'(1));
        check("best_ack_cyc", 128'(an), 128'(27));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
